host_mem_loader: RTL

- UART-driven initiator for the core's imem/dmem external write ports, which are currently tied to zero at the board top.
- Receives 8N1 byte frames from a host PC, assembles 32-bit words and issues single-cycle memory writes.
- Controls the core reset so programs can be loaded and then released without re-synthesis.
- Sits at the board top, between the UART pin and Core, in the clk_core domain.

---
 rtl/host_loader_pkg.sv | 27 ++
 rtl/uart_rx_byte.sv | 102 ++++++++++
 rtl/host_mem_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/host_loader_pkg.sv
// Shared command codes, FSM encodings and word geometry for the host memory loader.
package host_loader_pkg;

  localparam logic [7:0] CMD_WR_IMEM = 8'h01;
  localparam logic [7:0] CMD_WR_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;
  localparam logic [7:0] CMD_HALT    = 8'h04;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_DATA,
    S_WRITE
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes the line, times bits from a start edge and
// reports each byte as a one-cycle valid pulse or a framing error.
module uart_rx_byte
  import host_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 694
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  rx_state_t   r_state, w_next;
  logic [1:0]  r_sync;
  logic        r_rx_d;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_valid, r_ferr;
  logic [7:0]  r_data;
  logic        w_rx, w_fall, w_half, w_full;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_half = (r_cnt == 16'(HALF_BIT - 1));
  assign w_full = (r_cnt == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RX_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      // A start bit that is high again at its centre was a glitch.
      RX_START: if (w_half) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit_idx == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '1;
      r_rx_d    <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_data    <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_rx_d  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: r_cnt <= '0;
        RX_START: begin
          r_bit_idx <= '0;
          r_cnt     <= w_half ? '0 : r_cnt + 16'd1;
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_data;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/host_mem_loader.sv
// UART-driven loader for Core imem/dmem plus core reset control.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module host_mem_loader
  import host_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 80000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_WIDTH  = 12
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_enable,
  output logic                  imem_write,
  output logic [31:0]           imem_data_in,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_enable,
  output logic [3:0]            dmem_byte_write,
  output logic [31:0]           dmem_data_in,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  loader_state_t         r_state, w_next;
  logic                  w_byte_valid, w_frame_err, w_timeout, w_last_byte;
  logic [7:0]            w_byte;
  logic                  r_is_dmem, r_core_reset, r_error;
  logic [3:0]            r_addr_hi;
  logic [ADDR_WIDTH-1:0] r_addr, r_imem_addr, r_dmem_addr;
  logic [8:0]            r_count;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_word;
  logic [31:0]           r_imem_data, r_dmem_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_rx         (uart_rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte),
    .o_frame_err  (w_frame_err)
  );

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_to_cnt <= '0;
    else if (w_byte_valid || r_state == S_CMD) r_to_cnt <= '0;
    else if (!w_timeout)                      r_to_cnt <= r_to_cnt + 32'd1;
  end
  assign w_timeout = (r_state != S_CMD) && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_last_byte = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_CMD;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_frame_err || w_timeout) begin
      w_next = S_CMD;
    end else begin
      case (r_state)
        S_CMD:     if (w_byte_valid && (w_byte == CMD_WR_IMEM || w_byte == CMD_WR_DMEM))
                     w_next = S_ADDR_HI;
        S_ADDR_HI: if (w_byte_valid) w_next = (w_byte[7:4] != 4'h0) ? S_CMD : S_ADDR_LO;
        S_ADDR_LO: if (w_byte_valid) w_next = S_COUNT;
        S_COUNT:   if (w_byte_valid) w_next = S_DATA;
        S_DATA:    if (w_byte_valid && w_last_byte) w_next = S_WRITE;
        S_WRITE:   w_next = (r_count == 9'd1) ? S_CMD : S_DATA;
        default:   w_next = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_dmem    <= 1'b0;
      r_core_reset <= 1'b1;
      r_error      <= 1'b0;
      r_addr_hi    <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_imem_addr  <= '0;
      r_dmem_addr  <= '0;
      r_imem_data  <= '0;
      r_dmem_data  <= '0;
    end else begin
      if (r_state == S_WRITE) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count - 9'd1;
      end
      if (w_frame_err || w_timeout) begin
        r_error <= 1'b1;
      end else if (w_byte_valid) begin
        case (r_state)
          S_CMD: begin
            r_byte_cnt <= '0;
            case (w_byte)
              CMD_WR_IMEM: begin r_is_dmem <= 1'b0; r_core_reset <= 1'b1; r_error <= 1'b0; end
              CMD_WR_DMEM: begin r_is_dmem <= 1'b1; r_core_reset <= 1'b1; r_error <= 1'b0; end
              CMD_RUN:     begin r_core_reset <= 1'b0; r_error <= 1'b0; end
              CMD_HALT:    begin r_core_reset <= 1'b1; r_error <= 1'b0; end
              default:     r_error <= 1'b1;
            endcase
          end
          S_ADDR_HI: begin
            if (w_byte[7:4] != 4'h0) r_error <= 1'b1;
            else                     r_addr_hi <= w_byte[3:0];
          end
          S_ADDR_LO: r_addr  <= ADDR_WIDTH'({r_addr_hi, w_byte});
          S_COUNT:   r_count <= (w_byte == 8'h00) ? 9'd256 : {1'b0, w_byte};
          S_DATA: begin
            r_word     <= {r_word[15:0], w_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Output registers load only on the final byte so they hold between writes.
            if (w_last_byte) begin
              if (r_is_dmem) begin
                r_dmem_addr <= r_addr;
                r_dmem_data <= {r_word, w_byte};
              end else begin
                r_imem_addr <= r_addr;
                r_imem_data <= {r_word, w_byte};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr       = r_imem_addr;
  assign imem_data_in    = r_imem_data;
  assign imem_enable     = (r_state == S_WRITE) && !r_is_dmem;
  assign imem_write      = (r_state == S_WRITE) && !r_is_dmem;
  assign dmem_addr       = r_dmem_addr;
  assign dmem_data_in    = r_dmem_data;
  assign dmem_enable     = (r_state == S_WRITE) && r_is_dmem;
  assign dmem_byte_write = ((r_state == S_WRITE) && r_is_dmem) ? 4'hF : 4'h0;
  assign core_reset      = r_core_reset;
  assign busy            = (r_state != S_CMD);
  assign error           = r_error;

endmodule
